mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory of the RISC_V_Processor between the instruction-fetch port and the load/store port. Sits between the PC/fetch logic and the data-memory stage on one side and the memory macro on the other. Serialises one access at a time with a fixed-latency handshake and drives a stall signal that freezes the PC while any request is unserved.

---
 rtl/mem_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch
// port and the load/store port. Serves one access at a time through the
// sequence IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE. The read latency is
// fixed. The stall output holds the PC while any request is still unserved.
//
// Build option:
//   ARB_RR_EN  defined   : round-robin between the two ports on simultaneous
//                          requests. A last-served flag resets to "fetch".
//              undefined : fixed priority, with the data port over the fetch port.
//
// Parameter:
//   MEM_LAT    memory read latency in cycles, counted from ACCESS (>= 1)
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   if_req/if_addr       fetch request (level) and byte address
//   if_rdata/if_valid    fetched instruction and its one-cycle valid pulse
//   dm_req/dm_we         data request (level) and store(1)/load(0) select
//   dm_addr/dm_wdata     data byte address and store data
//   dm_rdata/dm_valid    load data and its one-cycle completion pulse
//   mem_en/mem_we        memory access strobe and write enable (ACCESS only)
//   mem_addr/mem_wdata   latched address / write data, held until next grant
//   mem_rdata            memory read data
//   stall                PC hold while a request is unserved

module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic [63:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;    // 1 = data port, 0 = fetch port
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [63:0]       dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              grant_dm_s;
  logic              capture_s;
`ifdef ARB_RR_EN
  logic              last_q, last_d;     // 1 = data served last, 0 = fetch
`endif

  // Arbitration: choose the data port when it should win this grant
  always_comb begin
    grant_dm_s = 1'b0;
`ifdef ARB_RR_EN
    if (dm_req && if_req) begin
      grant_dm_s = ~last_q;
    end else begin
      grant_dm_s = dm_req;
    end
`else
    grant_dm_s = dm_req;
`endif
  end

  // Next-state, latches and output pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    capture_s   = 1'b0;
`ifdef ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ACCESS;
          owner_d  = grant_dm_s;
          mem_en_d = 1'b1;
`ifdef ARB_RR_EN
          last_d   = grant_dm_s;
`endif
          if (grant_dm_s) begin
            we_d        = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            we_d        = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = 64'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d = CNT_LOAD;
        // With single-cycle memory the read data is already present now
        if (MEM_LAT > 1) begin
          state_d = WAIT;
        end else begin
          state_d   = DONE;
          capture_s = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = DONE;
          capture_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        // No grant here so the finished requester can drop or change its req
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if_valid_d = capture_s & ~owner_q;
    dm_valid_d = capture_s & owner_q;

    if (capture_s && !owner_q) begin
      if_rdata_d = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    end else begin
      if_rdata_d = if_rdata_q;
    end

    // Stores leave the previous load data in place
    if (capture_s && owner_q && !we_q) begin
      dm_rdata_d = mem_rdata;
    end else begin
      dm_rdata_d = dm_rdata_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 64'd0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
`ifdef ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
`ifdef ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign stall     = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Instance u2 uses MEM_LAT = 2 and
// instance u1 uses MEM_LAT = 1. The stimulus pushes the expected memory
// strobes and valid responses, each tagged with its cycle number. Monitors
// on the falling edge pop those entries and compare them against the DUT.
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rsp_t q_if2[$];
  rsp_t q_dm2[$];
  rsp_t q_dm1[$];
  mem_t q_mem2[$];
  mem_t q_mem1[$];

  // MEM_LAT = 2 instance signals
  logic        if_req2 = 1'b0, dm_req2 = 1'b0, dm_we2 = 1'b0;
  logic [63:0] if_addr2 = '0, dm_addr2 = '0, dm_wdata2 = '0, mem_rdata2 = '0;
  logic [31:0] if_rdata2;
  logic [63:0] dm_rdata2, mem_addr2, mem_wdata2;
  logic        if_valid2, dm_valid2, mem_en2, mem_we2, stall2;

  // MEM_LAT = 1 instance signals
  logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_we1 = 1'b0;
  logic [63:0] if_addr1 = '0, dm_addr1 = '0, dm_wdata1 = '0, mem_rdata1 = '0;
  logic [31:0] if_rdata1;
  logic [63:0] dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_valid1, dm_valid1, mem_en1, mem_we1, stall1;

  mem_port_arbiter #(.MEM_LAT(2)) u2 (
    .clk(clk), .reset(reset),
    .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_valid(if_valid2),
    .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
    .dm_rdata(dm_rdata2), .dm_valid(dm_valid2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .stall(stall2)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_valid(dm_valid1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall(stall1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an unexpected pulse, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_mem2(input int c, input logic we, input logic [63:0] a, input logic [63:0] wd);
    mem_t m;
    m.cyc = c; m.we = we; m.addr = a; m.wdata = wd;
    q_mem2.push_back(m);
  endtask

  task automatic push_rsp(input int port, input int c, input logic [63:0] d);
    rsp_t r;
    r.cyc = c; r.data = d;
    case (port)
      0: q_if2.push_back(r);
      1: q_dm2.push_back(r);
      default: q_dm1.push_back(r);
    endcase
  endtask

  task automatic check_reset2(input string tag);
    chk({tag, "_mem_en"}, 64'(mem_en2), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we2), 64'd0);
    chk({tag, "_if_valid"}, 64'(if_valid2), 64'd0);
    chk({tag, "_dm_valid"}, 64'(dm_valid2), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr2, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata2, 64'd0);
    chk({tag, "_if_rdata"}, 64'(if_rdata2), 64'd0);
    chk({tag, "_dm_rdata"}, dm_rdata2, 64'd0);
    chk({tag, "_stall"}, 64'(stall2), 64'd0);
  endtask

  // Monitor: pop and compare whenever a DUT presents an event
  always @(negedge clk) begin
    rsp_t r;
    mem_t m;
    if (if_valid2) begin
      if (q_if2.size() == 0) unexpected("if2_valid");
      else begin
        r = q_if2.pop_front();
        chk("if2_cycle", 64'(cyc), 64'(r.cyc));
        chk("if2_rdata", 64'(if_rdata2), r.data);
      end
    end
    if (dm_valid2) begin
      if (q_dm2.size() == 0) unexpected("dm2_valid");
      else begin
        r = q_dm2.pop_front();
        chk("dm2_cycle", 64'(cyc), 64'(r.cyc));
        chk("dm2_rdata", dm_rdata2, r.data);
      end
    end
    if (dm_valid1 || if_valid1) begin
      if (q_dm1.size() == 0 || if_valid1) unexpected("u1_valid");
      else begin
        r = q_dm1.pop_front();
        chk("dm1_cycle", 64'(cyc), 64'(r.cyc));
        chk("dm1_rdata", dm_rdata1, r.data);
      end
    end
    if (mem_en2) begin
      if (q_mem2.size() == 0) unexpected("mem2_en");
      else begin
        m = q_mem2.pop_front();
        chk("mem2_cycle", 64'(cyc), 64'(m.cyc));
        chk("mem2_we", 64'(mem_we2), 64'(m.we));
        chk("mem2_addr", mem_addr2, m.addr);
        if (m.we) chk("mem2_wdata", mem_wdata2, m.wdata);
      end
    end
    if (mem_en1) begin
      if (q_mem1.size() == 0) unexpected("mem1_en");
      else begin
        m = q_mem1.pop_front();
        chk("mem1_cycle", 64'(cyc), 64'(m.cyc));
        chk("mem1_we", 64'(mem_we1), 64'(m.we));
        chk("mem1_addr", mem_addr1, m.addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int   c0;
    mem_t m1;

    // Reset held for two cycles
    reset = 1'b1;
    step(1);
    @(negedge clk);
    check_reset2("rst");
    chk("rst_u1_dm_valid", 64'(dm_valid1), 64'd0);
    chk("rst_u1_mem_en", 64'(mem_en1), 64'd0);
    step(1);
    reset = 1'b0;

    // Fetch from 0x4 selects the upper word of mem_rdata
    c0 = cyc;
    if_req2 = 1'b1; if_addr2 = 64'h4;
    mem_rdata2 = 64'h00500093_11111111;
    push_mem2(c0 + 1, 1'b0, 64'h4, 64'd0);
    push_rsp(0, c0 + 3, 64'h00500093);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_stall", 64'(stall2), (k < 3) ? 64'd1 : 64'd0);
      step(1);
    end
    if_req2 = 1'b0;
    step(1);

    // Store: write strobe with wdata, dm_rdata keeps its old value
    c0 = cyc;
    dm_req2 = 1'b1; dm_we2 = 1'b1; dm_addr2 = 64'h10; dm_wdata2 = 64'hDEAD;
    mem_rdata2 = 64'h77777777_77777777;
    push_mem2(c0 + 1, 1'b1, 64'h10, 64'hDEAD);
    push_rsp(1, c0 + 3, 64'd0);
    step(4);
    dm_req2 = 1'b0; dm_we2 = 1'b0;
    step(2);

    // Reset clears the last-served flag, then both ports request together
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    c0 = cyc;
    if_req2 = 1'b1; if_addr2 = 64'h8;
    dm_req2 = 1'b1; dm_we2 = 1'b0; dm_addr2 = 64'h20;
    mem_rdata2 = 64'hAAAABBBB_CCCCDDDD;
    push_mem2(c0 + 1, 1'b0, 64'h20, 64'd0);
    push_rsp(1, c0 + 3, 64'hAAAABBBB_CCCCDDDD);
`ifdef ARB_RR_EN
    push_mem2(c0 + 5, 1'b0, 64'h8, 64'd0);
    push_rsp(0, c0 + 7, 64'h9ABCDEF0);
    push_mem2(c0 + 9, 1'b0, 64'h28, 64'd0);
    push_rsp(1, c0 + 11, 64'h12345678_9ABCDEF0);
`else
    push_mem2(c0 + 5, 1'b0, 64'h28, 64'd0);
    push_rsp(1, c0 + 7, 64'h12345678_9ABCDEF0);
    push_mem2(c0 + 9, 1'b0, 64'h8, 64'd0);
    push_rsp(0, c0 + 11, 64'h9ABCDEF0);
`endif
    step(4);
    dm_addr2 = 64'h28;                 // data port requests again
    mem_rdata2 = 64'h12345678_9ABCDEF0;
    step(4);
`ifdef ARB_RR_EN
    if_req2 = 1'b0;
`else
    dm_req2 = 1'b0;
`endif
    step(4);
    if_req2 = 1'b0; dm_req2 = 1'b0;
    step(2);

    // Reset during WAIT: no valid pulse, all outputs back to reset values
    c0 = cyc;
    if_req2 = 1'b1; if_addr2 = 64'h4;
    push_mem2(c0 + 1, 1'b0, 64'h4, 64'd0);
    step(2);
    reset = 1'b1; if_req2 = 1'b0;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check_reset2("midrst");
    step(4);

    // MEM_LAT = 1: WAIT is skipped, data sampled at the end of ACCESS
    c0 = cyc;
    dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 64'h8;
    mem_rdata1 = 64'h01010101_01010101;
    m1.cyc = c0 + 1; m1.we = 1'b0; m1.addr = 64'h8; m1.wdata = 64'd0;
    q_mem1.push_back(m1);
    push_rsp(2, c0 + 2, 64'hFEEDFACE_0BADF00D);
    step(1);
    mem_rdata1 = 64'hFEEDFACE_0BADF00D;
    step(1);
    mem_rdata1 = 64'h55555555_55555555;
    step(1);
    dm_req1 = 1'b0;
    step(3);

    // Every expected event must have been consumed
    chk("left_if2", 64'(q_if2.size()), 64'd0);
    chk("left_dm2", 64'(q_dm2.size()), 64'd0);
    chk("left_mem2", 64'(q_mem2.size()), 64'd0);
    chk("left_dm1", 64'(q_dm1.size()), 64'd0);
    chk("left_mem1", 64'(q_mem1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
